// File: rtl/alu_mdu_control.sv
// alu_mdu_control: ALU control decoder plus an iterative multiply/divide unit.
// Multiply is shift-add and divide is restoring, both on magnitudes, XLEN+1 cycles per op.
module alu_mdu_control #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ALUOp,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              is_mdu,
    output logic              stall,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [XLEN-1:0]   mdu_result
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4'b1011);
    localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(4'b1100);
    localparam logic [6:0] F7_Z   = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_M   = 7'b0000001;

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

    function automatic logic [CTRL_W-1:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return C_ADD;
            3'b001:  return C_SLL;
            3'b010:  return C_SLT;
            3'b011:  return C_SLTU;
            3'b100:  return C_XOR;
            3'b101:  return C_SRL;
            3'b110:  return C_OR;
            default: return C_AND;
        endcase
    endfunction

    always_comb begin
        alu_ctrl = C_ADD;
        illegal  = 1'b0;
        is_mdu   = 1'b0;
        case (ALUOp)
            2'b00: alu_ctrl = C_ADD;
            2'b01: alu_ctrl = C_SUB;
            2'b10: begin
                if (funct7 == F7_Z) alu_ctrl = base_op(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000) alu_ctrl = C_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) alu_ctrl = C_SRA;
                else if (funct7 == F7_M) is_mdu = 1'b1;
                else illegal = 1'b1;
            end
            default: begin
                if ((funct3 == 3'b001 && funct7 != F7_Z) ||
                    (funct3 == 3'b101 && funct7 != F7_Z && funct7 != F7_ALT)) illegal = 1'b1;
                else if (funct3 == 3'b101 && funct7 == F7_ALT) alu_ctrl = C_SRA;
                else alu_ctrl = base_op(funct3);
            end
        endcase
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic              an_q, an_d, bn_q, bn_d;

    // hi:lo is the running product for multiply, remainder:quotient for divide
    logic              a_neg, b_neg, neg_p;
    logic [XLEN:0]     mul_t, div_r, div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   q_s, r_s, fin;

    assign a_neg    = operand_a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110);
    assign b_neg    = operand_b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    assign mul_t    = lo_q[0] ? {1'b0, hi_q} + {1'b0, m_q} : {1'b0, hi_q};
    assign div_r    = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_r - {1'b0, m_q};
    assign neg_p    = an_q ^ bn_q;
    assign prod_s   = neg_p ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign q_s      = m_q == '0 ? '1 : (neg_p ? -lo_q : lo_q);
    assign r_s      = an_q ? -hi_q : hi_q;
    assign fin      = op_q[2] ? (op_q[1] ? r_s : q_s)
                              : (op_q == 3'b000 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        op_d     = op_q;
        an_d     = an_q;
        bn_d     = bn_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (valid_in && is_mdu && !flush) begin
                state_d = BUSY;
                cnt_d   = '0;
                hi_d    = '0;
                lo_d    = a_neg ? -operand_a : operand_a;
                m_d     = b_neg ? -operand_b : operand_b;
                op_d    = funct3;
                an_d    = a_neg;
                bn_d    = b_neg;
            end
            BUSY: if (cnt_q == CNT_W'(XLEN)) begin
                state_d  = DONE;
                result_d = fin;
            end else begin
                cnt_d = cnt_q + 1'b1;
                hi_d  = op_q[2] ? (div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0]) : mul_t[XLEN:1];
                lo_d  = op_q[2] ? {lo_q[XLEN-2:0], ~div_diff[XLEN]} : {mul_t[0], lo_q[XLEN-1:1]};
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            op_q     <= '0;
            an_q     <= 1'b0;
            bn_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            op_q     <= op_d;
            an_q     <= an_d;
            bn_q     <= bn_d;
            result_q <= result_d;
        end
    end

    assign stall      = valid_in & is_mdu & (state_q != DONE);
    assign mdu_busy   = state_q == BUSY;
    assign mdu_done   = state_q == DONE;
    assign mdu_result = result_q;
endmodule
